divisor_sched: RTL

Run-time controller for the team's clock divider path. It generates a divided clock `Clk_out` from `Clk_in` with a programmable half-period. Requesters reconfigure the ratio through a valid/ready handshake. New ratios and stop requests take effect only at period boundaries, so `Clk_out` never glitches or produces a runt pulse. It sits between the system configuration logic and the peripherals clocked by the divided output.

---
 rtl/divisor_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/divisor_sched.sv
`default_nettype none
// ============================================================================
// Module   : divisor_sched
// Brief    : Glitch-free programmable clock divider with valid/ready ratio
//            reconfiguration and safe start/stop at period boundaries.
//            Optional status outputs under DIVISOR_SCHED_STATUS_EN.
// Revision : 1.0
// ============================================================================
module divisor_sched #(
    parameter int frecuency       = 50000000,
    parameter int reference_clock = 1000000,
    parameter int cnt_width       = 16
) (
    input  logic                 Clk_in,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 cfg_valid,
    input  logic [cnt_width-1:0] cfg_half,
    output logic                 cfg_ready,
    output logic                 Clk_out,
    output logic                 tick
`ifdef DIVISOR_SCHED_STATUS_EN
    ,
    output logic [cnt_width-1:0] active_half,
    output logic [1:0]           sched_state
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int                   c_default_int  = frecuency / (2 * reference_clock);
    localparam logic [cnt_width-1:0] c_default_half = cnt_width'(c_default_int);
    localparam logic [cnt_width-1:0] c_one          = cnt_width'(1);

    state_t               r_state,      w_state_nxt;
    logic [cnt_width-1:0] r_cnt,        w_cnt_nxt;
    logic [cnt_width-1:0] r_half,       w_half_nxt;
    logic [cnt_width-1:0] r_pend,       w_pend_nxt;
    logic                 r_pend_valid, w_pend_valid_nxt;
    logic                 r_clk_out,    w_clk_out_nxt;
    logic                 r_tick,       w_tick_nxt;

    logic [cnt_width-1:0] w_eff_half;
    logic                 w_wrap;

    // A programmed half-period of zero runs as one, giving Clk_in/2.
    assign w_eff_half = (r_half == '0) ? c_one : r_half;
    assign w_wrap     = (r_cnt == (w_eff_half - c_one));

    assign cfg_ready = !r_pend_valid;
    assign Clk_out   = r_clk_out;
    assign tick      = r_tick;

    always_ff @(posedge Clk_in or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_half       <= c_default_half;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_half       <= w_half_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_clk_out    <= w_clk_out_nxt;
            r_tick       <= w_tick_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_half_nxt       = r_half;
        w_pend_nxt       = r_pend;
        w_pend_valid_nxt = r_pend_valid;
        w_clk_out_nxt    = r_clk_out;
        w_tick_nxt       = 1'b0;

        // Acceptance and application are mutually exclusive: one needs the
        // pending slot empty, the other needs it full.
        if (cfg_valid && !r_pend_valid) begin
            w_pend_nxt       = cfg_half;
            w_pend_valid_nxt = 1'b1;
        end

        case (r_state)
            IDLE: begin
                w_clk_out_nxt = 1'b0;
                w_cnt_nxt     = '0;
                if (r_pend_valid) begin
                    w_half_nxt       = r_pend;
                    w_pend_valid_nxt = 1'b0;
                end
                if (enable) begin
                    w_state_nxt   = RUN;
                    w_clk_out_nxt = 1'b1;
                    w_tick_nxt    = 1'b1;
                end
            end
            RUN: begin
                if (enable || r_clk_out) begin
                    if (w_wrap) begin
                        w_cnt_nxt     = '0;
                        w_clk_out_nxt = !r_clk_out;
                        if (r_clk_out) begin
                            if (r_pend_valid) begin
                                w_half_nxt       = r_pend;
                                w_pend_valid_nxt = 1'b0;
                            end
                            if (!enable) begin
                                w_state_nxt = IDLE;
                            end
                        end else begin
                            w_tick_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                        // High phase must complete in full before stopping.
                        if (!enable) begin
                            w_state_nxt = DRAIN;
                        end
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            DRAIN: begin
                if (w_wrap) begin
                    w_cnt_nxt     = '0;
                    w_clk_out_nxt = 1'b0;
                    w_state_nxt   = IDLE;
                    if (r_pend_valid) begin
                        w_half_nxt       = r_pend;
                        w_pend_valid_nxt = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_cnt_nxt     = '0;
                w_clk_out_nxt = 1'b0;
            end
        endcase
    end

`ifdef DIVISOR_SCHED_STATUS_EN
    assign active_half = r_half;
    assign sched_state = r_state;
`endif

endmodule
`default_nettype wire
